sobel_output_unpacker: RTL

- Sits directly after sobel_filter on its output side.
- Accepts 128-bit gray result words (16 pixels per word, no backpressure) and buffers them in a small word FIFO.
- Serialises them into one interleaved RGB pixel per beat (gray replicated to R,G,B) over a valid/ready stream toward the frame writer/DMA.
- Marks end-of-word and end-of-frame.

---
 rtl/sobel_pkg.sv | 40 ++++
 rtl/sobel_word_fifo.sv | 73 +++++++
 rtl/sobel_output_unpacker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared types and constants for the Sobel output path: 128-bit
//            gray block, 8-bit pixel, packed RGB pixel and channel indices.
// Revision : 1.0  initial release
// ============================================================================
package sobel_pkg;

    typedef bit [127:0] block_t;
    typedef bit [7:0]   pixel_t;

    // R occupies the most significant byte of the packed pixel
    typedef struct packed {
        pixel_t r;
        pixel_t g;
        pixel_t b;
    } rgb_t;

    localparam int PIXELS_PER_BLOCK = 16;

    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int BLUE  = 2;

    // Replicate one gray sample onto all three colour channels
    function automatic rgb_t gray_to_rgb(input pixel_t gray);
        pixel_t ch [3];
        rgb_t   px;
        ch[RED]   = gray;
        ch[GREEN] = gray;
        ch[BLUE]  = gray;
        px.r      = ch[RED];
        px.g      = ch[GREEN];
        px.b      = ch[BLUE];
        return px;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sobel_word_fifo
// Purpose  : Synchronous word FIFO with level output. A push while full is
//            accepted when a pop happens in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module sobel_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,        // synchronous, active-low
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_accept,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_lvl_w  = c_addr_w + 1;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0]  r_level;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_level == c_lvl_w'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word if the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_accept  = w_do_push;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage write; no word is captured while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_output_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : sobel_output_unpacker
// Purpose  : Buffers 128-bit gray words from the Sobel filter and serialises
//            them as one RGB pixel per valid/ready beat, flagging the last
//            pixel of each word and of each frame.
// Revision : 1.0  initial release
// ============================================================================
module sobel_output_unpacker
    import sobel_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                   clk,
    input  logic                   rst,          // synchronous, active-low
    input  logic [127:0]           data_in,
    input  logic                   valid_in,
    output logic [23:0]            out_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   out_eof,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int c_idx_w = $clog2(PIXELS_PER_BLOCK);
    localparam int c_cnt_w = $clog2(FRAME_PIXELS);
    localparam int c_lvl_w = $clog2(DEPTH) + 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PIXELS_PER_BLOCK - 1);
    localparam logic [c_cnt_w-1:0] c_last_pix = c_cnt_w'(FRAME_PIXELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_pix_cnt;
    logic                 r_overflow;

    logic [127:0]         w_head_raw;
    block_t               w_head;
    pixel_t               w_gray;
    rgb_t                 w_rgb;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_full;
    logic                 w_empty;
    logic [c_lvl_w-1:0]   w_level;

    sobel_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (valid_in),
        .i_data   (data_in),
        .i_pop    (w_pop),
        .o_head   (w_head_raw),
        .o_accept (w_accept),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (w_level)
    );

    assign w_head   = block_t'(w_head_raw);
    assign w_gray   = w_head[{r_idx, 3'b000} +: 8];
    assign w_rgb    = gray_to_rgb(w_gray);
    // Output flags depend only on registered state, so the handshake does too
    assign w_hs     = (r_state == ST_STREAM) && out_ready;
    assign w_pop    = w_hs && (r_idx == c_last_idx) && !w_empty;
    assign level    = w_level;
    assign overflow = r_overflow;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream outputs; idle drives a zero pixel
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_pixel   = '0;
        out_last    = 1'b0;
        out_eof     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                out_pixel = w_rgb;
                out_last  = (r_idx == c_last_idx);
                out_eof   = (r_pix_cnt == c_last_pix);
                // Leave only when the final word drains with no refill
                if (w_pop && (w_level == c_lvl_w'(1)) && !w_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte index within the head word and frame pixel counter, per handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx     <= '0;
            r_pix_cnt <= '0;
        end else if (w_hs) begin
            r_idx     <= r_idx + c_idx_w'(1);
            r_pix_cnt <= (r_pix_cnt == c_last_pix) ? '0 : r_pix_cnt + c_cnt_w'(1);
        end
    end

    // Sticky drop flag: a word arrived with no room and no pop to make room
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (valid_in && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire
